// File: rtl/smii_phy_ep.sv
// SMII PHY-side endpoint: segment alignment from SYNC, TX segment decode,
// RX segment generation (data or in-band status) with 10M repetition.
module smii_phy_ep #(
    parameter int unsigned SAMPLE_REP = 0
) (
    input  logic       phy_smii_ref_clk,
    input  logic       rst_async,
    input  logic       phy_smii_sync,
    input  logic       phy_smii_txd,
    output logic       phy_smii_rxd,
    input  logic       cfg_speed,
    input  logic       cfg_duplex,
    input  logic       cfg_link,
    input  logic       cfg_jabber,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_er,
    output logic       rx_ready,
    output logic       tx_valid,
    output logic       tx_en,
    output logic       tx_er,
    output logic [7:0] tx_data,
    output logic       locked,
    output logic       sync_err
);

    typedef enum logic {
        ST_HUNT,
        ST_LOCKED
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  idx;          // predicted bit index of the current cycle
    logic [3:0]  idx_eff;      // bit index after honouring SYNC
    logic [3:0]  idx_next;
    logic [3:0]  rep;          // repetition number of the current segment
    logic [3:0]  rep_next;
    logic        seg_speed;    // speed in force for the current segment
    logic        err_sticky;
    logic        last_status;  // previous loaded RX segment was a status one
    logic [8:0]  tx_sr;        // TXD bits 0..8; bit 9 is taken live
    logic [9:0]  rx_sr;
    logic [9:0]  new_seg;
    logic [9:0]  seg_src;
    logic        realign;
    logic        lost;
    logic        seg_end;
    logic        load;
    logic        decode;

    // Alignment FSM next state, segment events and RX segment selection.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        state_next = state;
        realign    = 1'b0;
        lost       = 1'b0;
        idx_eff    = phy_smii_sync ? 4'd0 : idx;
        idx_next   = (idx_eff == 4'd9) ? 4'd0 : idx_eff + 4'd1;

        if (state == ST_HUNT) begin
            if (phy_smii_sync) begin
                state_next = ST_LOCKED;
            end
        end else begin
            if (phy_smii_sync && (idx != 4'd0)) begin
                realign = 1'b1;
            end else if (!phy_smii_sync && (idx == 4'd0)) begin
                lost       = 1'b1;
                state_next = ST_HUNT;
            end
        end

        // A realign forces idx_eff to 0, so it always beats a pending load.
        seg_end  = (state == ST_LOCKED) && (idx_eff == 4'd9);
        load     = seg_end && (seg_speed || (rep == 4'd9));
        decode   = seg_end && (seg_speed || (rep == 4'(SAMPLE_REP)));
        rep_next = (seg_speed || cfg_speed || (rep == 4'd9)) ? 4'd0 : rep + 4'd1;

        if (rx_valid) begin
            new_seg = {rx_data, 2'b11};
        end else begin
            new_seg = {1'b1, 2'b00, cfg_jabber, cfg_link, cfg_duplex, cfg_speed,
                       err_sticky, 1'b0, ~cfg_duplex & tx_en};
        end
        seg_src  = load ? new_seg : rx_sr;
        rx_ready = load && rx_valid;
    end

    assign locked = (state == ST_LOCKED);

    // FSM state register and error pulse.
    always_ff @(posedge phy_smii_ref_clk or posedge rst_async) begin
        if (rst_async) begin
            state    <= ST_HUNT;
            sync_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state    <= state_next;
            sync_err <= realign | lost;
        end
    end

    // Bit index, repetition counter and per-segment speed.
    always_ff @(posedge phy_smii_ref_clk or posedge rst_async) begin
        if (rst_async) begin
            idx       <= 4'd0;
            rep       <= 4'd0;
            seg_speed <= 1'b0;
        end else begin
            idx <= idx_next;
            if ((state == ST_HUNT) && phy_smii_sync) begin
                rep       <= 4'd0;
                seg_speed <= cfg_speed;
            end else if (seg_end) begin
                rep       <= rep_next;
                seg_speed <= cfg_speed;
            end
        end
    end

    // TX sampling and segment decode.
    always_ff @(posedge phy_smii_ref_clk or posedge rst_async) begin
        if (rst_async) begin
            // NOTE: the small shift registers are reset too; they are flops, not a RAM.
            tx_sr    <= 9'd0;
            tx_valid <= 1'b0;
            tx_en    <= 1'b0;
            tx_er    <= 1'b0;
            tx_data  <= 8'd0;
        end else begin
            if (idx_eff != 4'd9) begin
                tx_sr[idx_eff] <= phy_smii_txd;
            end
            tx_valid <= decode;
            if (decode) begin
                tx_er   <= tx_sr[0];
                tx_en   <= tx_sr[1];
                tx_data <= {phy_smii_txd, tx_sr[8:2]};
            end
        end
    end

    // RX segment register, serial output and receive error tracking.
    always_ff @(posedge phy_smii_ref_clk or posedge rst_async) begin
        if (rst_async) begin
            rx_sr        <= 10'd0;
            phy_smii_rxd <= 1'b0;
            err_sticky   <= 1'b0;
            last_status  <= 1'b1;
        end else begin
            if (state_next == ST_HUNT) begin
                rx_sr <= 10'd0;
            end else if (load) begin
                rx_sr <= new_seg;
            end
            phy_smii_rxd <= (state_next == ST_LOCKED) ? seg_src[idx_next] : 1'b0;
            if (load) begin
                if (rx_valid) begin
                    err_sticky  <= (last_status ? 1'b0 : err_sticky) | rx_er;
                    last_status <= 1'b0;
                end else begin
                    last_status <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_smii_phy_ep.sv
// Directed bench for smii_phy_ep: acts as the MAC, driving SYNC/TXD per
// segment and collecting RXD bits and handshake pulses.
module tb_smii_phy_ep;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync = 1'b0;
    logic       txd = 1'b0;
    logic       rxd;
    logic       cfg_speed = 1'b1;
    logic       cfg_duplex = 1'b0;
    logic       cfg_link = 1'b1;
    logic       cfg_jabber = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_er = 1'b0;
    logic       rx_ready;
    logic       tx_valid;
    logic       tx_en;
    logic       tx_er;
    logic [7:0] tx_data;
    logic       locked;
    logic       sync_err;

    int         checks = 0;
    int         failures = 0;
    logic [9:0] rx_bits;
    logic [9:0] cap_tx;
    logic       lock_k1;
    int         tv_cnt;
    int         rr_cnt;
    int         se_cnt;
    int         tv_tot;
    int         rr_tot;

    smii_phy_ep #(.SAMPLE_REP(3)) dut (
        .phy_smii_ref_clk (clk),
        .rst_async        (rst),
        .phy_smii_sync    (sync),
        .phy_smii_txd     (txd),
        .phy_smii_rxd     (rxd),
        .cfg_speed        (cfg_speed),
        .cfg_duplex       (cfg_duplex),
        .cfg_link         (cfg_link),
        .cfg_jabber       (cfg_jabber),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_er            (rx_er),
        .rx_ready         (rx_ready),
        .tx_valid         (tx_valid),
        .tx_en            (tx_en),
        .tx_er            (tx_er),
        .tx_data          (tx_data),
        .locked           (locked),
        .sync_err         (sync_err)
    );

    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive n cycles of one segment (bit k in cycle k, SYNC on k=0 if asked);
    // sample outputs mid-cycle and record RXD bits and pulse counts.
    task automatic send_seg(input logic [9:0] bits, input logic do_sync, input int n,
                            input logic rv, input logic [7:0] rd, input logic re);
        tv_cnt  = 0;
        rr_cnt  = 0;
        se_cnt  = 0;
        lock_k1 = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sync = do_sync && (k == 0);
            txd  = bits[k];
            if (k == 0) begin
                rx_valid = rv;
                rx_data  = rd;
                rx_er    = re;
            end
            #1;
            rx_bits[k] = rxd;
            if (tx_valid) begin
                tv_cnt++;
                cap_tx = {tx_en, tx_er, tx_data};
            end
            if (rx_ready) rr_cnt++;
            if (sync_err) se_cnt++;
            if (k == 1) lock_k1 = locked;
        end
        sync = 1'b0;
    endtask

    function automatic logic [14:0] out_vec();
        return {rxd, rx_ready, tx_valid, tx_en, tx_er, tx_data, locked, sync_err};
    endfunction

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 32'(out_vec()), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 100M: lock, decode 0x55, status and data segments
        send_seg(10'h156, 1'b1, 10, 1'b0, 8'h00, 1'b0);
        check("s1_locked", 32'(lock_k1), 32'h1);
        send_seg(10'h30F, 1'b1, 10, 1'b0, 8'h00, 1'b0);
        check("s2_tv", tv_cnt, 1);
        check("s2_tx_55", 32'(cap_tx), 32'h255);
        check("s2_rx_status", 32'(rx_bits), 32'h228);
        send_seg(10'h156, 1'b1, 10, 1'b1, 8'hA5, 1'b1);
        check("s3_tx_c3", 32'(cap_tx), 32'h3C3);
        check("s3_rx_status_crs", 32'(rx_bits), 32'h229);
        check("s3_rr", rr_cnt, 1);
        send_seg(10'h156, 1'b1, 10, 1'b0, 8'h00, 1'b0);
        check("s4_rx_data_a5", 32'(rx_bits), 32'h297);
        check("s4_rr", rr_cnt, 0);
        send_seg(10'h156, 1'b1, 10, 1'b0, 8'h00, 1'b0);
        check("s5_rx_status_err", 32'(rx_bits), 32'h22D);
        send_seg(10'h156, 1'b1, 10, 1'b1, 8'h3C, 1'b0);
        check("s6_rx_status_err", 32'(rx_bits), 32'h22D);
        check("s6_rr", rr_cnt, 1);
        send_seg(10'h156, 1'b1, 10, 1'b0, 8'h00, 1'b0);
        check("s7_rx_data_3c", 32'(rx_bits), 32'h0F3);
        send_seg(10'h156, 1'b1, 10, 1'b0, 8'h00, 1'b0);
        check("s8_rx_err_cleared", 32'(rx_bits), 32'h229);

        // SYNC at idx 4: realign, stay locked, decode continues
        send_seg(10'h156, 1'b1, 4, 1'b0, 8'h00, 1'b0);
        send_seg(10'h30F, 1'b1, 10, 1'b0, 8'h00, 1'b0);
        check("realign_sync_err", se_cnt, 1);
        check("realign_locked", 32'(lock_k1), 32'h1);
        check("realign_no_tv", tv_cnt, 0);
        send_seg(10'h156, 1'b1, 10, 1'b0, 8'h00, 1'b0);
        check("realign_tv", tv_cnt, 1);
        check("realign_tx_c3", 32'(cap_tx), 32'h3C3);

        // Missing SYNC: error, HUNT, rxd forced low
        send_seg(10'h156, 1'b0, 10, 1'b0, 8'h00, 1'b0);
        check("lost_sync_err", se_cnt, 1);
        check("lost_locked", 32'(lock_k1), 32'h0);
        check("lost_rxd_zero", 32'(rx_bits >> 1), 32'h0);
        send_seg(10'h156, 1'b0, 10, 1'b0, 8'h00, 1'b0);
        check("hunt_no_err", se_cnt, 0);
        check("hunt_no_tv", tv_cnt, 0);
        check("hunt_locked", 32'(lock_k1), 32'h0);

        // 10M with SAMPLE_REP=3: one decode and one RX load per 10 segments
        cfg_speed = 1'b0;
        tv_tot = 0;
        rr_tot = 0;
        for (int j = 0; j < 10; j++) begin
            send_seg(10'h206, 1'b1, 10, 1'b1, 8'h96, 1'b0);
            tv_tot += tv_cnt;
            rr_tot += rr_cnt;
        end
        check("g1_tv", tv_tot, 1);
        check("g1_tx_81", 32'(cap_tx), 32'h281);
        check("g1_rr", rr_tot, 1);
        tv_tot = 0;
        rr_tot = 0;
        for (int j = 0; j < 10; j++) begin
            send_seg(10'h30F, 1'b1, 10, 1'b1, 8'h69, 1'b0);
            check($sformatf("g2_rx_rep%0d", j), 32'(rx_bits), 32'h25B);
            tv_tot += tv_cnt;
            rr_tot += rr_cnt;
        end
        check("g2_tv", tv_tot, 1);
        check("g2_tx_c3", 32'(cap_tx), 32'h3C3);
        check("g2_rr", rr_tot, 1);

        // Reset mid-segment for 3 cycles, then relock at 100M
        cfg_speed = 1'b1;
        send_seg(10'h156, 1'b1, 5, 1'b0, 8'h00, 1'b0);
        rx_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_c0", 32'(out_vec()), 32'h0);
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("midrst_c%0d", c), 32'(out_vec()), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        send_seg(10'h30F, 1'b1, 10, 1'b0, 8'h00, 1'b0);
        check("relock_no_tv", tv_cnt, 0);
        check("relock_no_rr", rr_cnt, 0);
        check("relock_locked", 32'(lock_k1), 32'h1);
        send_seg(10'h156, 1'b1, 10, 1'b0, 8'h00, 1'b0);
        check("relock_tv", tv_cnt, 1);
        check("relock_tx_c3", 32'(cap_tx), 32'h3C3);
        check("relock_rx_status", 32'(rx_bits), 32'h228);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
